bias_buf_ctrl: RTL and testbench
================================

Name: bias_buf_ctrl

Overview:
- Controller for the 384 x 32b bias SRAM macro wrapper.
- Load phase: accepts a DMA word stream and writes biases to consecutive SRAM addresses starting at 0.
- Fetch phase: reads the biases back in address order and presents them to the accumulator/post-process stage as a valid/ready stream.
- Absorbs the SRAM's one-cycle read latency with a 2-entry output FIFO so backpressure never loses data.

Parameters:
- DEPTH, 384, number of SRAM words; requests above this are clamped to it.
- AW, 9, SRAM address width.
- DW, 32, bias data width.

Ports:
- clk  in  1  clock; also drives the SRAM CK.
- rst  in  1  synchronous, active-high reset.
- start_load  in  1  one-cycle pulse; begins the load phase (IDLE only).
- start_fetch  in  1  one-cycle pulse; begins the fetch phase (IDLE only).
- num_words  in  AW  word count; sampled on an accepted start.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse when a phase completes.
- dma_valid  in  1  write-stream valid.
- dma_ready  out  1  write-stream ready.
- dma_data  in  DW  bias word to write.
- bias_valid  out  1  output-stream valid.
- bias_ready  in  1  output-stream ready.
- bias_data  out  DW  bias word read from the SRAM.
- bias_idx  out  AW  SRAM address of bias_data.
- sram_cs  out  1  chip select.
- sram_oe  out  1  output enable.
- sram_web  out  1  write enable, active low.
- sram_a  out  AW  SRAM address.
- sram_di  out  DW  SRAM write data.
- sram_do  in  DW  SRAM read data; valid the cycle after the read is issued.

Behaviour:
- Reset values: state IDLE; all counters 0; FIFO empty.
- Reset output values: busy=0, done=0, dma_ready=0, bias_valid=0, bias_data=0, bias_idx=0, sram_cs=0, sram_oe=0, sram_web=1, sram_a=0, sram_di=0.
- Reset mid-operation: abort immediately to IDLE, flush FIFO and any in-flight read, no done pulse.
- States: IDLE, LOAD, FETCH, DONE.
- Start handling in IDLE:
  - start_load -> LOAD; start_fetch -> FETCH.
  - Both asserted together: start_load wins; start_fetch is dropped.
  - n = min(num_words, DEPTH) is latched on the accepted start.
  - n = 0: go directly to DONE; no SRAM access.
  - Starts outside IDLE are ignored.
- LOAD:
  - dma_ready=1 while wr_cnt < n.
  - On dma_valid && dma_ready in the same cycle: sram_cs=1, sram_web=0, sram_a=wr_cnt, sram_di=dma_data (combinational); wr_cnt increments.
  - When the write with wr_cnt = n-1 is accepted: next state DONE, and dma_ready drops the following cycle.
- FETCH:
  - sram_oe=1 throughout.
  - Read issue condition: rd_cnt < n && (fifo_cnt + inflight - pop) < 2, where pop = bias_valid && bias_ready.
  - On issue: sram_cs=1, sram_web=1, sram_a=rd_cnt; rd_cnt increments; inflight=1 for the next cycle.
  - Next cycle: sram_do and its address are pushed into the FIFO at the clock edge.
  - bias_valid = FIFO non-empty; bias_data and bias_idx come from the FIFO head.
  - Ready held high: the first bias_valid appears 2 cycles after entering FETCH, then one word per cycle.
  - Push and pop in the same cycle are allowed; FIFO never overflows.
  - Data and idx are held stable while bias_valid && !bias_ready.
  - FETCH -> DONE on the pop of the word with idx n-1.
- DONE: done=1 for exactly one cycle, then IDLE. busy is high in DONE and low in IDLE.
- Outside active accesses: sram_cs=0 and sram_web=1.
- Addresses never exceed DEPTH-1; counters do not wrap.

Test Plan:
- Reset, then load n=4 with data 0x11,0x22,0x33,0x44 back-to-back -> writes to addresses 0..3 with sram_web=0 on four consecutive cycles; done pulses once; dma_ready=0 afterwards.
- Fetch n=4, bias_ready=1 -> bias_valid starts at cycle 2 after FETCH entry; outputs 0x11..0x44 with idx 0..3 on consecutive cycles; done one cycle after the last pop.
- Fetch n=4 with bias_ready toggling 1,0,0,1,... -> no loss or duplication; data held while stalled; at most 2 outstanding reads plus FIFO entries at any time.
- num_words=500 on load with a 384-word stream -> exactly 384 writes, last at address 383, then done. num_words=0 -> done one cycle after start, sram_cs never asserted.
- start_load and start_fetch in the same cycle -> load runs. start_fetch during LOAD -> ignored.
- rst asserted mid-FETCH with 1 FIFO entry and 1 read in flight -> next cycle: IDLE, bias_valid=0, sram_cs=0, no done; a new fetch restarts from address 0.

Source files
------------

// File: rtl/bias_buf_ctrl.sv
// Bias SRAM controller: DMA load into the 384x32 macro, then in-order fetch
// to the post-process stage through a 2-entry skid FIFO.
module bias_buf_ctrl #(
  parameter int DEPTH = 384,
  parameter int AW    = 9,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_load,
  input  logic          start_fetch,
  input  logic [AW-1:0] num_words,
  output logic          busy,
  output logic          done,
  input  logic          dma_valid,
  output logic          dma_ready,
  input  logic [DW-1:0] dma_data,
  output logic          bias_valid,
  input  logic          bias_ready,
  output logic [DW-1:0] bias_data,
  output logic [AW-1:0] bias_idx,
  output logic          sram_cs,
  output logic          sram_oe,
  output logic          sram_web,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_di,
  input  logic [DW-1:0] sram_do
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LP_DEPTH = AW'(DEPTH);
  localparam logic [AW-1:0] LP_ONE   = AW'(1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_n;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [AW-1:0] r_infl_idx;
  logic          r_inflight;
  logic [DW-1:0] r_fd [2];
  logic [AW-1:0] r_fi [2];
  logic          r_wp;
  logic          r_rp;
  logic [1:0]    r_fcnt;

  logic [AW-1:0] w_n_clamp;
  logic          w_go_load;
  logic          w_go_fetch;
  logic          w_wr;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic          w_last_pop;
  logic [2:0]    w_occ;

  assign w_n_clamp  = (num_words > LP_DEPTH) ? LP_DEPTH : num_words;
  assign w_go_load  = (r_state == S_IDLE) && start_load;
  assign w_go_fetch = (r_state == S_IDLE) && start_fetch && !start_load;

  assign dma_ready  = (r_state == S_LOAD) && (r_wr_cnt < r_n);
  assign w_wr       = dma_valid && dma_ready;

  assign bias_valid = (r_fcnt != 2'd0);
  assign w_pop      = bias_valid && bias_ready;
  assign w_push     = r_inflight;

  // Slots committed after this edge: held entries plus the read in flight.
  assign w_occ      = {1'b0, r_fcnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue    = (r_state == S_FETCH) && (r_rd_cnt < r_n)
                   && (w_occ < 3'd2);
  assign w_last_pop = w_pop && (r_fi[r_rp] == r_n - LP_ONE);

  assign bias_data  = bias_valid ? r_fd[r_rp] : '0;
  assign bias_idx   = bias_valid ? r_fi[r_rp] : '0;

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign sram_oe    = (r_state == S_FETCH);
  assign sram_cs    = w_wr || w_issue;
  assign sram_web   = !w_wr;
  assign sram_a     = w_wr ? r_wr_cnt : (w_issue ? r_rd_cnt : '0);
  assign sram_di    = w_wr ? dma_data : '0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start_load || start_fetch) begin
          if (w_n_clamp == '0) w_next = S_DONE;
          else if (start_load) w_next = S_LOAD;
          else w_next = S_FETCH;
        end
      end
      S_LOAD: begin
        if (w_wr && (r_wr_cnt == r_n - LP_ONE)) w_next = S_DONE;
      end
      S_FETCH: begin
        if (w_last_pop) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_infl_idx <= '0;
      r_inflight <= 1'b0;
      r_fd[0]    <= '0;
      r_fd[1]    <= '0;
      r_fi[0]    <= '0;
      r_fi[1]    <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_fcnt     <= 2'd0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_go_load || w_go_fetch) begin
        r_n      <= w_n_clamp;
        r_wr_cnt <= '0;
        r_rd_cnt <= '0;
      end
      if (w_wr) r_wr_cnt <= r_wr_cnt + LP_ONE;
      if (w_issue) begin
        r_rd_cnt   <= r_rd_cnt + LP_ONE;
        r_infl_idx <= r_rd_cnt;
      end
      if (w_push) begin
        r_fd[r_wp] <= sram_do;
        r_fi[r_wp] <= r_infl_idx;
        r_wp       <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_fcnt <= r_fcnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: tb/tb_bias_buf_ctrl.sv
// Bench for bias_buf_ctrl: behavioural SRAM, shadow memory of loaded words,
// directed steps with randomized data, valid and ready patterns.
module tb_bias_buf_ctrl;
  localparam int DEPTH = 384;
  localparam int AW    = 9;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_load;
  logic          start_fetch;
  logic [AW-1:0] num_words;
  logic          busy;
  logic          done;
  logic          dma_valid;
  logic          dma_ready;
  logic [DW-1:0] dma_data;
  logic          bias_valid;
  logic          bias_ready;
  logic [DW-1:0] bias_data;
  logic [AW-1:0] bias_idx;
  logic          sram_cs;
  logic          sram_oe;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_di;
  logic [DW-1:0] sram_do;

  always #5 clk = ~clk;

  bias_buf_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .start_fetch(start_fetch),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .dma_valid  (dma_valid),
    .dma_ready  (dma_ready),
    .dma_data   (dma_data),
    .bias_valid (bias_valid),
    .bias_ready (bias_ready),
    .bias_data  (bias_data),
    .bias_idx   (bias_idx),
    .sram_cs    (sram_cs),
    .sram_oe    (sram_oe),
    .sram_web   (sram_web),
    .sram_a     (sram_a),
    .sram_di    (sram_di),
    .sram_do    (sram_do)
  );

  logic [DW-1:0] sram_mem [0:DEPTH-1];
  logic [DW-1:0] sram_q = '0;

  always @(posedge clk) begin
    if (sram_cs) begin
      if (!sram_web) sram_mem[sram_a] <= sram_di;
      else sram_q <= sram_mem[sram_a];
    end
  end
  assign sram_do = sram_q;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] ref_mem [0:DEPTH-1];

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int nw, input int pv, input bit fixed,
                         input bit both, input int poke);
    int n;
    int k;
    int cyc;
    int writes;
    logic [DW-1:0] d;
    n = (nw > DEPTH) ? DEPTH : nw;
    k = 0;
    cyc = 0;
    writes = 0;
    bias_ready = 1'b0;
    num_words = nw[AW-1:0];
    start_load = 1'b1;
    start_fetch = both;
    tick();
    start_load = 1'b0;
    start_fetch = 1'b0;
    while (k < n && cyc < 20 * n + 50) begin
      d = fixed ? DW'(32'h11 * (k + 1)) : DW'($urandom);
      dma_data = d;
      dma_valid = ($urandom_range(0, 99) < pv);
      start_fetch = (cyc == poke);
      @(negedge clk);
      chk("load_busy", busy, 1);
      chk("load_oe", sram_oe, 0);
      chk("load_dma_ready", dma_ready, 1);
      if (dma_valid) begin
        chk("load_cs", sram_cs, 1);
        chk("load_web", sram_web, 0);
        chk("load_addr", sram_a, k);
        chk("load_di", sram_di, d);
        ref_mem[k] = d;
        k++;
        writes++;
      end else begin
        chk("load_idle_cs", sram_cs, 0);
      end
      tick();
      cyc++;
    end
    dma_valid = 1'b0;
    start_fetch = 1'b0;
    if (k < n) chk("load_timeout", k, n);
    @(negedge clk);
    chk("load_done", done, 1);
    chk("load_done_busy", busy, 1);
    chk("load_ready_low", dma_ready, 0);
    chk("load_done_cs", sram_cs, 0);
    chk("load_writes", writes, n);
    tick();
    @(negedge clk);
    chk("load_idle_busy", busy, 0);
    chk("load_idle_done", done, 0);
    chk("load_idle_ready", dma_ready, 0);
  endtask

  task automatic do_fetch(input int nw, input int mode);
    int n;
    int k;
    int c;
    int issued;
    int first_c;
    bit stall;
    n = (nw > DEPTH) ? DEPTH : nw;
    k = 0;
    c = 0;
    issued = 0;
    first_c = -1;
    stall = 1'b0;
    num_words = nw[AW-1:0];
    start_fetch = 1'b1;
    tick();
    start_fetch = 1'b0;
    while (k < n && c < 20 * n + 50) begin
      if (mode == 0) bias_ready = 1'b1;
      else if (mode == 1) bias_ready = (c % 3 == 0);
      else bias_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      chk("fetch_oe", sram_oe, 1);
      chk("fetch_done_low", done, 0);
      if (sram_cs) begin
        chk("fetch_web", sram_web, 1);
        chk("fetch_addr", sram_a, issued);
        issued++;
      end
      if (stall) chk("hold_valid", bias_valid, 1);
      if (mode == 0 && c >= 2) chk("stream_gap", bias_valid, 1);
      if (bias_valid) begin
        if (first_c < 0) begin
          first_c = c;
          if (mode == 0) chk("first_valid_lat", c, 2);
        end
        chk("bias_data", bias_data, ref_mem[k]);
        chk("bias_idx", bias_idx, k);
        stall = !bias_ready;
        if (bias_ready) k++;
      end else begin
        stall = 1'b0;
      end
      chk("outstanding_le2", (issued - k) <= 2, 1);
      tick();
      c++;
    end
    bias_ready = 1'b0;
    if (k < n) chk("fetch_timeout", k, n);
    @(negedge clk);
    chk("fetch_done", done, 1);
    chk("fetch_done_busy", busy, 1);
    chk("fetch_done_valid", bias_valid, 0);
    chk("fetch_done_cs", sram_cs, 0);
    chk("fetch_reads", issued, n);
    tick();
    @(negedge clk);
    chk("fetch_idle_busy", busy, 0);
    chk("fetch_idle_done", done, 0);
  endtask

  initial begin
    int nw;
    rst = 1'b1;
    start_load = 1'b0;
    start_fetch = 1'b0;
    num_words = '0;
    dma_valid = 1'b0;
    dma_data = '0;
    bias_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dma_ready", dma_ready, 0);
    chk("rst_bias_valid", bias_valid, 0);
    chk("rst_bias_data", bias_data, 0);
    chk("rst_bias_idx", bias_idx, 0);
    chk("rst_cs", sram_cs, 0);
    chk("rst_oe", sram_oe, 0);
    chk("rst_web", sram_web, 1);
    chk("rst_a", sram_a, 0);
    chk("rst_di", sram_di, 0);
    rst = 1'b0;
    tick();

    do_load(4, 100, 1'b1, 1'b0, -1);
    do_fetch(4, 0);
    do_fetch(4, 1);

    do_load(500, 70, 1'b0, 1'b0, -1);
    do_fetch(450, 2);

    do_load(0, 100, 1'b0, 1'b0, -1);
    do_fetch(0, 0);

    do_load(6, 100, 1'b0, 1'b1, -1);
    do_fetch(6, 0);
    do_load(8, 60, 1'b0, 1'b0, 3);
    do_fetch(8, 1);

    for (int i = 0; i < 4; i++) begin
      nw = $urandom_range(1, 40);
      do_load(nw, $urandom_range(30, 100), 1'b0, 1'b0, -1);
      do_fetch(nw, $urandom_range(0, 2));
    end

    num_words = 9'd4;
    start_fetch = 1'b1;
    tick();
    start_fetch = 1'b0;
    bias_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("pre_rst_valid", bias_valid, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", bias_valid, 0);
    chk("mid_rst_cs", sram_cs, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_web", sram_web, 1);
    tick();
    @(negedge clk);
    chk("post_rst_done", done, 0);
    chk("post_rst_valid", bias_valid, 0);
    do_fetch(4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
